// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - memory and ALU bus between the control unit and its datapath
// The control unit is the master; memory and ALU sit on the slave side.
interface control_unit_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata,
    output alu_op,
    output alu_a,
    output alu_b,
    input  alu_result
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata,
    input  alu_op,
    input  alu_a,
    input  alu_b,
    output alu_result
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - accumulator machine sequencer: fetch/decode/operand-read/execute FSM
// Memory reads are registered, so every operand costs one address cycle before its data is usable.
module control_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  control_unit_if.master     bus,
  output logic [15:0]        pc,
  output logic [15:0]        acc,
  output logic [15:0]        ir,
  output logic [2:0]         state,
  output logic               halted
);

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_OPREAD  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ALU   = 4'h3;
  localparam logic [3:0] OP_JUMP  = 4'h4;
  localparam logic [3:0] OP_JZ    = 4'h5;

  logic [3:0]  op;
  logic [3:0]  fetched_op;
  logic [15:0] addr12_ext;
  logic [15:0] addr8_ext;
  logic        acc_zero;

  assign op         = ir[15:12];
  assign fetched_op = bus.mem_rdata[15:12];
  assign addr12_ext = {4'h0, ir[11:0]};
  assign addr8_ext  = {8'h00, ir[7:0]};
  assign acc_zero   = (acc == 16'h0000);
  assign halted     = (state == ST_HALT);

  always_comb begin
    bus.mem_addr  = pc;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = acc;
    bus.alu_a     = acc;
    bus.alu_b     = bus.mem_rdata;
    bus.alu_op    = ir[11:8];
    case (state)
      ST_OPREAD: begin
        if (op == OP_LOAD) bus.mem_addr = addr12_ext;
        else               bus.mem_addr = addr8_ext;
      end
      ST_EXECUTE: begin
        if (op == OP_STORE) begin
          bus.mem_addr = addr12_ext;
          // Gate with reset so a write is dropped the instant reset rises, not one flop delay later.
          bus.mem_we   = ~reset;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      acc   <= 16'h0000;
      ir    <= 16'h0000;
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir <= bus.mem_rdata;
          pc <= pc + 16'd1;
          case (fetched_op)
            OP_HALT:                  state <= ST_HALT;
            OP_LOAD, OP_ALU:          state <= ST_OPREAD;
            OP_STORE, OP_JUMP, OP_JZ: state <= ST_EXECUTE;
            default:                  state <= ST_FETCH;
          endcase
        end
        ST_OPREAD: state <= ST_EXECUTE;
        ST_EXECUTE: begin
          case (op)
            OP_LOAD: acc <= bus.mem_rdata;
            OP_ALU:  acc <= bus.alu_result;
            OP_JUMP: pc  <= addr12_ext;
            OP_JZ:   if (acc_zero) pc <= addr12_ext;
            default: ;
          endcase
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 16'h0000, the program counter value loaded on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have the following data ports:
- mem_addr  output  16  main memory address.
- mem_wdata  output  16  main memory write data.
- mem_we  output  1  main memory write enable.
- mem_rdata  input  16  main memory read data; registered, valid one cycle after its address is driven with mem_we=0.
- alu_op  output  4  ALU operation code.
- alu_a  output  16  ALU operand1.
- alu_b  output  16  ALU operand2.
- alu_result  input  16  combinational ALU result.
- pc  output  16  program counter.
- acc  output  16  accumulator.
- ir  output  16  instruction register.
- state  output  3  FSM state: FETCH=0, DECODE=1, OPREAD=2, EXECUTE=3, HALT=4.
- halted  output  1  high while state==HALT.

Function
REQ-004 Instruction fields SHALL be: op=ir[15:12]; addr12=ir[11:0]; aluop=ir[11:8]; addr8=ir[7:0].
REQ-005 Op encoding SHALL be: 0x0 HALT, 0x1 LOAD, 0x2 STORE, 0x3 ALU, 0x4 JUMP, 0x5 JZ, 0x6-0xF NOP.
REQ-006 Default outputs SHALL be: mem_addr=pc, mem_we=0, mem_wdata=acc, alu_a=acc, alu_b=mem_rdata, alu_op=ir[11:8]. These defaults SHALL be combinational and hold in every state unless a state overrides them.
REQ-007 FETCH SHALL drive mem_addr=pc with mem_we=0, then go to DECODE.
REQ-008 In DECODE the block SHALL:
- set ir <= mem_rdata;
- set pc <= pc+1, with 16'hFFFF wrapping to 16'h0000;
- select the next state from mem_rdata[15:12]: HALT->HALT; LOAD and ALU->OPREAD; STORE, JUMP and JZ->EXECUTE; NOP->FETCH.
REQ-009 OPREAD SHALL drive mem_addr as follows, with mem_we=0, then go to EXECUTE:
- LOAD: {4'h0, addr12}.
- ALU: {8'h00, addr8}.
REQ-010 EXECUTE SHALL perform the following, then go to FETCH:
- LOAD: acc <= mem_rdata.
- ALU: acc <= alu_result.
- STORE: mem_addr={4'h0, addr12}, mem_we=1 for exactly this one cycle.
- JUMP: pc <= {4'h0, addr12}.
- JZ: pc <= {4'h0, addr12} if acc==16'h0000; otherwise pc is unchanged.
REQ-011 HALT SHALL be terminal: no register changes, mem_we=0, halted=1, exit only via reset.
REQ-012 Instruction latency SHALL be:
- LOAD and ALU: 4 cycles;
- STORE, JUMP and JZ: 3 cycles;
- NOP: 2 cycles;
- HALT: halted asserts 2 cycles after FETCH.
REQ-013 mem_we SHALL be 1 only in EXECUTE of a STORE.
REQ-014 JZ SHALL test acc as it stands at EXECUTE, including a value written by the immediately preceding instruction.
REQ-015 The block SHALL latch alu_result unmodified, including ALU divide-by-zero results; the block adds no arithmetic checks.

Reset
REQ-016 While reset=1 the block SHALL asynchronously set: pc=RESET_PC, acc=0, ir=0, state=FETCH, halted=0, mem_we=0.
REQ-017 Reset asserted in any state, including the EXECUTE cycle of a STORE, SHALL deassert mem_we immediately with no memory write. The first FETCH SHALL be the first rising clk edge after reset deasserts.

Verification
REQ-018 The bench SHALL run this program: mem[0]=0x1010, mem[1]=0x3011, mem[2]=0x2012, mem[3]=0x0000, mem[0x10]=5, mem[0x11]=7. Required response: acc=12, mem[0x12]=0x000C, halted=1 after 13 cycles, pc=4.
REQ-019 The bench SHALL check JZ in both directions:
- Taken: acc=0, mem[0]=0x5020 -> pc=0x0020 after 3 cycles.
- Not taken: acc=3 -> pc=0x0001.
REQ-020 The bench SHALL check wrap-around: RESET_PC=16'hFFFF, mem[0xFFFF] NOP (0x6000) -> pc=0x0000 after DECODE.
REQ-021 The bench SHALL check reset during a write: reset asserted in STORE EXECUTE -> mem_we=0 in the same cycle, target word unchanged, pc=RESET_PC, state=FETCH.
REQ-022 The bench SHALL check the ALU path: mem[0]=0x3A05 with acc=0x00FF, mem[5]=0x0F0F -> alu_op=4'hA, alu_b=0x0F0F, acc=0x0FF0 after EXECUTE.
REQ-023 The bench SHALL check HALT: mem[0]=0x0000 -> halted=1, state=4, and pc, acc and ir stable for 20 further cycles with mem_we=0.
